idecode_stage: RTL and testbench

Parametrised RV32I decode stage with hazard support. Successor to the fixed-width decode stage. It decodes InstrD, reads a bypassing register file, and generates the immediate and control word. It registers everything into an ID/EX pipeline register that supports stall and flush, and exports source/destination register numbers to the hazard unit. It sits between the IF/ID register and the execute stage. Writeback enters through an explicit RegWriteW/RdW/ResultW port.

---
 rtl/idecode_pkg.sv | 72 +++++++
 rtl/idec_regfile.sv | 41 ++++
 rtl/idecode_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_idecode_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idecode_pkg.sv
// Shared decode-stage types: opcodes, immediate kinds, ALU ops
// and the control word carried through the ID/EX register.
package idecode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_src_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        jalr;
    logic        branch;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        valid;
    logic        illegal;
    result_src_t result_src;
    alu_ctl_t    alu_ctl;
    logic [2:0]  funct3;
  } ctrl_t;

  function automatic alu_ctl_t alu_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_ctl_t r;
    unique case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idec_regfile.sv
// Register file with x0 hardwired to zero and a same-cycle
// write-to-read bypass so decode sees writeback data at once.
module idec_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr;

  assign wr = we && (rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr) begin
      regs[rd] <= wdata;
    end
  end

  always_comb begin
    rd1 = (rs1 == '0) ? '0 : regs[rs1];
    rd2 = (rs2 == '0) ? '0 : regs[rs2];
    if (wr && rd == rs1) rd1 = wdata;
    if (wr && rd == rs2) rd2 = wdata;
  end

endmodule

// File: rtl/idecode_stage.sv
// RV32I decode stage: controller, immediate extension, bypassing
// register file and a stall/flush-capable ID/EX register.
module idecode_stage
  import idecode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [AW-1:0]   Rs1D,
  output logic [AW-1:0]   Rs2D,
  output logic            IllegalD,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            JalrE,
  output logic            BranchE,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic            ValidE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output alu_ctl_t        ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [AW-1:0]   Rs1E,
  output logic [AW-1:0]   Rs2E,
  output logic [AW-1:0]   RdE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  logic [6:0]      op;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [AW-1:0]   rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
  logic [31:0]     imm32;
  ctrl_t           c;
  imm_src_t        imm_src;
  logic            bad_op, bad_reg;
  logic            use_rs1, use_rs2, use_rd;

  assign op   = InstrD[6:0];
  assign f3   = InstrD[14:12];
  assign f7   = InstrD[31:25];
  assign Rs1D = InstrD[15 +: AW];
  assign Rs2D = InstrD[20 +: AW];
  assign rd_d = InstrD[7 +: AW];

  function automatic logic over(input logic [4:0] r);
    return {1'b0, r} >= 6'(NREGS);
  endfunction

  idec_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .rs1   (Rs1D),
    .rs2   (Rs2D),
    .we    (RegWriteW),
    .rd    (RdW),
    .wdata (ResultW),
    .rd1   (rd1_d),
    .rd2   (rd2_d)
  );

  always_comb begin
    c = '0;
    c.funct3 = f3;
    c.alu_ctl = ALU_ADD;
    c.result_src = RES_ALU;
    imm_src = IMM_I;
    bad_op = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd = 1'b0;
    unique case (1'b1)
      (op == OP_R): begin
        c.reg_write = 1'b1;
        c.alu_ctl = alu_op(f3, f7[5]);
        {use_rs1, use_rs2, use_rd} = 3'b111;
        bad_op = !(f7 == 7'h00 ||
          (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      (op == OP_I): begin
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.alu_ctl = alu_op(f3, f3 == 3'b101 && f7[5]);
        {use_rs1, use_rd} = 2'b11;
        if (f3 == 3'b001) bad_op = f7 != 7'h00;
        if (f3 == 3'b101) bad_op = !(f7 == 7'h00 || f7 == 7'h20);
      end
      (op == OP_LOAD): begin
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.result_src = RES_MEM;
        {use_rs1, use_rd} = 2'b11;
        bad_op = f3 != 3'b010;
      end
      (op == OP_STORE): begin
        c.mem_write = 1'b1;
        c.alu_src_b = 1'b1;
        imm_src = IMM_S;
        {use_rs1, use_rs2} = 2'b11;
        bad_op = f3 != 3'b010;
      end
      (op == OP_BRANCH): begin
        c.branch = 1'b1;
        c.alu_ctl = ALU_SUB;
        imm_src = IMM_B;
        {use_rs1, use_rs2} = 2'b11;
        bad_op = f3[2:1] == 2'b01;
      end
      (op == OP_JAL): begin
        c.jump = 1'b1;
        c.reg_write = 1'b1;
        c.result_src = RES_PC4;
        imm_src = IMM_J;
        use_rd = 1'b1;
      end
      (op == OP_JALR): begin
        c.jalr = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.result_src = RES_PC4;
        {use_rs1, use_rd} = 2'b11;
        bad_op = f3 != 3'b000;
      end
      (op == OP_LUI): begin
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.alu_ctl = ALU_PASSB;
        imm_src = IMM_U;
        use_rd = 1'b1;
      end
      (op == OP_AUIPC): begin
        c.reg_write = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 1'b1;
        imm_src = IMM_U;
        use_rd = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase
    // only index fields the format actually uses can be out of range
    bad_reg = (use_rs1 && over(InstrD[19:15])) ||
              (use_rs2 && over(InstrD[24:20])) ||
              (use_rd && over(InstrD[11:7]));
    IllegalD = bad_op || bad_reg;
    c.valid = ValidD;
    c.illegal = IllegalD && ValidD;
    if (IllegalD || !ValidD) begin
      c.reg_write = 1'b0;
      c.mem_write = 1'b0;
      c.jump = 1'b0;
      c.jalr = 1'b0;
      c.branch = 1'b0;
    end
  end

  always_comb begin
    unique case (imm_src)
      IMM_S: imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm32 = {{20{InstrD[31]}}, InstrD[7],
                      InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm32 = {{12{InstrD[31]}}, InstrD[19:12],
                      InstrD[20], InstrD[30:21], 1'b0};
      IMM_U: imm32 = {InstrD[31:12], 12'h000};
      default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  assign imm_d = XLEN'($signed(imm32));

  ctrl_t           ctrl_e;
  logic [AW-1:0]   rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrl_e <= '0;
      rs1_e <= '0;
      rs2_e <= '0;
      rd_e <= '0;
      rd1_e <= '0;
      rd2_e <= '0;
      imm_e <= '0;
      pc_e <= '0;
      pc4_e <= '0;
    end else if (!StallE) begin
      ctrl_e <= c;
      rs1_e <= Rs1D;
      rs2_e <= Rs2D;
      rd_e <= rd_d;
      rd1_e <= rd1_d;
      rd2_e <= rd2_d;
      imm_e <= imm_d;
      pc_e <= PCD;
      pc4_e <= PCPlus4D;
    end
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign JumpE       = ctrl_e.jump;
  assign JalrE       = ctrl_e.jalr;
  assign BranchE     = ctrl_e.branch;
  assign ALUSrcAE    = ctrl_e.alu_src_a;
  assign ALUSrcBE    = ctrl_e.alu_src_b;
  assign ValidE      = ctrl_e.valid;
  assign IllegalE    = ctrl_e.illegal;
  assign ResultSrcE  = ctrl_e.result_src;
  assign ALUControlE = ctrl_e.alu_ctl;
  assign Funct3E     = ctrl_e.funct3;
  assign Rs1E        = rs1_e;
  assign Rs2E        = rs2_e;
  assign RdE         = rd_e;
  assign RD1E        = rd1_e;
  assign RD2E        = rd2_e;
  assign ImmExtE     = imm_e;
  assign PCE         = pc_e;
  assign PCPlus4E    = pc4_e;

endmodule

// File: tb/tb_idecode_stage.sv
// Scoreboard bench for idecode_stage: random and directed decode
// traffic against an instruction-level reference model.
module tb_idecode_stage;
  import idecode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit / 32-register instance
  logic        reset = 1'b1;
  logic [31:0] instr = '0, pc = '0, pc4 = '0, wb_data = '0;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
  logic        ill_d, rw_e, mw_e, j_e, jr_e, br_e, sa_e, sb_e, v_e, il_e;
  logic [1:0]  rs_e;
  alu_ctl_t    alu_e;
  logic [2:0]  f3_e;
  logic [31:0] d1_e, d2_e, imm_e, pc_e, pc4_e;

  idecode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .InstrD(instr), .PCD(pc),
    .PCPlus4D(pc4), .ValidD(valid), .StallE(stall),
    .FlushE(flush), .RegWriteW(wb_en), .RdW(wb_rd),
    .ResultW(wb_data), .Rs1D(rs1_d), .Rs2D(rs2_d),
    .IllegalD(ill_d), .RegWriteE(rw_e), .MemWriteE(mw_e),
    .JumpE(j_e), .JalrE(jr_e), .BranchE(br_e),
    .ALUSrcAE(sa_e), .ALUSrcBE(sb_e), .ValidE(v_e),
    .IllegalE(il_e), .ResultSrcE(rs_e), .ALUControlE(alu_e),
    .Funct3E(f3_e), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e),
    .RD1E(d1_e), .RD2E(d2_e), .ImmExtE(imm_e), .PCE(pc_e),
    .PCPlus4E(pc4_e)
  );

  // 64-bit / 16-register instance
  logic        b_reset = 1'b1;
  logic [31:0] b_instr = '0;
  logic [63:0] b_pc = '0, b_pc4 = '0, b_wdata = '0;
  logic        b_valid = 1'b0, b_wen = 1'b0;
  logic [3:0]  b_wrd = '0;
  logic [3:0]  b_rs1_d, b_rs2_d, b_rs1_e, b_rs2_e, b_rd_e;
  logic        b_ill_d, b_rw, b_mw, b_j, b_jr, b_br, b_sa, b_sb;
  logic        b_v, b_il;
  logic [1:0]  b_rs;
  alu_ctl_t    b_alu;
  logic [2:0]  b_f3;
  logic [63:0] b_d1, b_d2, b_imm, b_pce, b_pc4e;
  bit          b_done = 1'b0;

  idecode_stage #(.XLEN(64), .NREGS(16)) dut64 (
    .clk(clk), .reset(b_reset), .InstrD(b_instr), .PCD(b_pc),
    .PCPlus4D(b_pc4), .ValidD(b_valid), .StallE(1'b0),
    .FlushE(1'b0), .RegWriteW(b_wen), .RdW(b_wrd),
    .ResultW(b_wdata), .Rs1D(b_rs1_d), .Rs2D(b_rs2_d),
    .IllegalD(b_ill_d), .RegWriteE(b_rw), .MemWriteE(b_mw),
    .JumpE(b_j), .JalrE(b_jr), .BranchE(b_br),
    .ALUSrcAE(b_sa), .ALUSrcBE(b_sb), .ValidE(b_v),
    .IllegalE(b_il), .ResultSrcE(b_rs), .ALUControlE(b_alu),
    .Funct3E(b_f3), .Rs1E(b_rs1_e), .Rs2E(b_rs2_e),
    .RdE(b_rd_e), .RD1E(b_d1), .RD2E(b_d2), .ImmExtE(b_imm),
    .PCE(b_pce), .PCPlus4E(b_pc4e)
  );

  task automatic check(input string n, input logic [63:0] a,
                       input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  typedef struct {
    bit          full, has_imm, bad;
    logic        rw, mw, j, jr, br, sa, sb, v, il;
    logic [1:0]  rs;
    alu_ctl_t    alu;
    logic [2:0]  f3;
    logic [4:0]  r1, r2, rd;
    logic [31:0] d1, d2, imm, pc, pc4;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] rf [32];

  function automatic exp_t zero_e();
    exp_t e;
    e.full = 1; e.has_imm = 1; e.bad = 0;
    {e.rw, e.mw, e.j, e.jr, e.br, e.sa, e.sb, e.v, e.il} = '0;
    e.rs = 2'b00; e.alu = ALU_ADD; e.f3 = '0;
    e.r1 = '0; e.r2 = '0; e.rd = '0;
    e.d1 = '0; e.d2 = '0; e.imm = '0; e.pc = '0; e.pc4 = '0;
    return e;
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 0) return '0;
    if (wb_en && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  // Instruction-level model: what each mnemonic asks of EX
  function automatic exp_t ref_dec(input logic [31:0] w,
                                   input logic v);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok;
    alu_ctl_t tab [8];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e = zero_e();
    e.f3 = f3; e.r1 = w[19:15]; e.r2 = w[24:20]; e.rd = w[11:7];
    e.d1 = rd_reg(e.r1); e.d2 = rd_reg(e.r2);
    e.pc = pc; e.pc4 = pc4;
    ok = 1;
    case (op)
      OP_R: begin
        e.has_imm = 0; e.rw = 1;
        ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu = (f7 == 7'h20) ? (f3 == 0 ? ALU_SUB : ALU_SRA)
                              : tab[f3];
      end
      OP_I: begin
        e.rw = 1; e.sb = 1;
        e.imm = 32'($signed(w[31:20]));
        if (f3 == 1) ok = f7 == 0;
        if (f3 == 5) ok = f7 == 0 || f7 == 7'h20;
        e.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : tab[f3];
      end
      OP_LOAD: begin
        ok = f3 == 2; e.rw = 1; e.sb = 1; e.rs = 2'b01;
        e.imm = 32'($signed(w[31:20]));
      end
      OP_STORE: begin
        ok = f3 == 2; e.mw = 1; e.sb = 1;
        e.imm = 32'($signed({w[31:25], w[11:7]}));
      end
      OP_BRANCH: begin
        ok = f3 != 2 && f3 != 3; e.br = 1; e.alu = ALU_SUB;
        e.imm = 32'($signed({w[31], w[7], w[30:25],
                             w[11:8], 1'b0}));
      end
      OP_JAL: begin
        e.j = 1; e.rw = 1; e.rs = 2'b10;
        e.imm = 32'($signed({w[31], w[19:12], w[20],
                             w[30:21], 1'b0}));
      end
      OP_JALR: begin
        ok = f3 == 0; e.jr = 1; e.rw = 1; e.sb = 1; e.rs = 2'b10;
        e.imm = 32'($signed(w[31:20]));
      end
      OP_LUI: begin
        e.rw = 1; e.sb = 1; e.alu = ALU_PASSB;
        e.imm = {w[31:12], 12'h000};
      end
      OP_AUIPC: begin
        e.rw = 1; e.sa = 1; e.sb = 1;
        e.imm = {w[31:12], 12'h000};
      end
      default: ok = 0;
    endcase
    e.bad = !ok;
    e.full = ok;
    e.v = v;
    e.il = !ok && v;
    if (!ok || !v) {e.rw, e.mw, e.j, e.jr, e.br} = '0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [9];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    w = $urandom;
    if ($urandom_range(7) != 0) begin
      w[6:0] = ops[$urandom_range(8)];
      if ($urandom_range(3) != 0)
        w[31:25] = $urandom_range(1) ? 7'h00 : 7'h20;
      if ((w[6:0] == OP_LOAD || w[6:0] == OP_STORE) &&
          $urandom_range(3) != 0)
        w[14:12] = 3'b010;
      if (w[6:0] == OP_JALR && $urandom_range(3) != 0)
        w[14:12] = 3'b000;
    end
    return w;
  endfunction

  task automatic drive(input logic r, input logic [31:0] w,
                       input logic v, input logic st,
                       input logic fl, input logic we,
                       input logic [4:0] wrd,
                       input logic [31:0] wd);
    exp_t e, nxt;
    @(negedge clk);
    reset = r; instr = w; valid = v; stall = st; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    pc = $urandom & 32'hFFFF_FFFC;
    pc4 = pc + 4;
    e = ref_dec(w, v);
    if (r || fl) nxt = zero_e();
    else if (st) nxt = cur;
    else nxt = e;
    q.push_back(nxt);
    cur = nxt;
    #1;
    if (!r) begin
      check("IllegalD", ill_d, e.bad);
      check("Rs1D", rs1_d, w[19:15]);
      check("Rs2D", rs2_d, w[24:20]);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
    end else if (we && wrd != 0) begin
      rf[wrd] = wd;
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever EX presents after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("RegWriteE", rw_e, e.rw);
        check("MemWriteE", mw_e, e.mw);
        check("JumpE", j_e, e.j);
        check("JalrE", jr_e, e.jr);
        check("BranchE", br_e, e.br);
        check("ValidE", v_e, e.v);
        check("IllegalE", il_e, e.il);
        check("Funct3E", f3_e, e.f3);
        check("Rs1E", rs1_e, e.r1);
        check("Rs2E", rs2_e, e.r2);
        check("RdE", rd_e, e.rd);
        check("RD1E", d1_e, e.d1);
        check("RD2E", d2_e, e.d2);
        check("PCE", pc_e, e.pc);
        check("PCPlus4E", pc4_e, e.pc4);
        if (e.full) begin
          check("ALUSrcAE", sa_e, e.sa);
          check("ALUSrcBE", sb_e, e.sb);
          check("ResultSrcE", rs_e, e.rs);
          check("ALUControlE", alu_e, e.alu);
          if (e.has_imm) check("ImmExtE", imm_e, e.imm);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    b_reset = 1'b0; b_valid = 1'b1; b_instr = 32'hFFF00093;
    edge1();
    check("w64 addi -1 imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64 addi rw", b_rw, 1);
    @(negedge clk);
    b_instr = 32'h00100A13;
    #1;
    check("w64 rd20 IllegalD", b_ill_d, 1);
    edge1();
    check("w64 rd20 IllegalE", b_il, 1);
    check("w64 rd20 rw", b_rw, 0);
    @(negedge clk);
    b_instr = 32'h00100793;
    #1;
    check("w64 rd15 IllegalD", b_ill_d, 0);
    @(negedge clk);
    b_instr = 32'h800000B7;
    edge1();
    check("w64 lui imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    b_instr = 32'h000100B3;
    b_wen = 1'b1; b_wrd = 4'd2; b_wdata = 64'h1234_5678_9ABC_DEF0;
    edge1();
    check("w64 bypass RD1E", b_d1, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    b_wen = 1'b0;
    b_instr = 32'h002000B3;
    edge1();
    check("w64 stored RD2E", b_d2, 64'h1234_5678_9ABC_DEF0);
    b_done = 1'b1;
  end

  initial begin
    logic [31:0] sw_i;
    logic        r;
    cur = zero_e();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    edge1();
    check("reset RegWriteE", rw_e, 0);
    check("reset ValidE", v_e, 0);

    drive(0, 32'h00500093, 1, 0, 0, 0, 0, 0);
    edge1();
    check("addi RegWriteE", rw_e, 1);
    check("addi ALUSrcBE", sb_e, 1);
    check("addi ImmExtE", imm_e, 5);
    check("addi Rs1E", rs1_e, 0);
    check("addi RdE", rd_e, 1);
    check("addi ALUControlE", alu_e, ALU_ADD);

    drive(0, 32'h003100B3, 1, 0, 0, 1, 3, 32'hDEADBEEF);
    edge1();
    check("bypass RD2E", d2_e, 32'hDEADBEEF);
    drive(0, 32'h000100B3, 1, 0, 0, 1, 0, 32'h12345678);
    edge1();
    check("x0 write RD2E", d2_e, 0);
    drive(0, 32'h000000B3, 1, 0, 0, 0, 0, 0);
    edge1();
    check("x0 read RD1E", d1_e, 0);

    sw_i = 32'hFE512E23;
    drive(0, sw_i, 1, 0, 0, 0, 0, 0);
    edge1();
    check("sw MemWriteE", mw_e, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, rand_instr(), 1, 1, 0, 1, 5'($urandom), $urandom);
      edge1();
      check("stall MemWriteE", mw_e, 1);
      check("stall ImmExtE", imm_e, 32'hFFFFFFFC);
    end
    drive(0, rand_instr(), 1, 1, 1, 0, 0, 0);
    edge1();
    check("flush ValidE", v_e, 0);
    check("flush MemWriteE", mw_e, 0);

    drive(0, 32'hFFFFF0B7, 1, 0, 0, 0, 0, 0);
    edge1();
    check("lui ImmExtE", imm_e, 32'hFFFFF000);
    check("lui ALUControlE", alu_e, ALU_PASSB);
    drive(0, 32'hFE000AE3, 1, 0, 0, 0, 0, 0);
    edge1();
    check("beq BranchE", br_e, 1);
    check("beq ImmExtE", imm_e, 32'hFFFFFFF4);
    check("beq Funct3E", f3_e, 0);
    check("beq RegWriteE", rw_e, 0);

    drive(0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
    edge1();
    check("ill IllegalE", il_e, 1);
    check("ill RegWriteE", rw_e, 0);
    check("ill MemWriteE", mw_e, 0);
    drive(0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    edge1();
    check("bubble ValidE", v_e, 0);

    drive(0, 32'h00500093, 1, 0, 0, 1, 7, 32'h55);
    drive(1, 32'h00500093, 1, 0, 0, 0, 0, 0);
    edge1();
    check("midreset ValidE", v_e, 0);
    check("midreset RegWriteE", rw_e, 0);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(199) == 0);
      drive(r, rand_instr(), $urandom_range(7) != 0,
            $urandom_range(5) == 0, $urandom_range(9) == 0,
            $urandom_range(1) == 1, 5'($urandom), $urandom);
    end
    @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    check("w64 sequence done", b_done, 1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
